fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter ADDR_W, default 5, program-counter and instruction-address width.
REQ-002 SHALL provide parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port imem_addr  output  ADDR_W  instruction memory read address, equal to the current PC.
REQ-006 SHALL provide port imem_instr  input  32  combinational read data returned for imem_addr in the same cycle.
REQ-007 SHALL provide port halt  input  1  when high, suppresses new fetches.
REQ-008 SHALL provide port redirect_valid  input  1  requests a PC change and a pipeline flush.
REQ-009 SHALL provide port redirect_pc  input  ADDR_W  target PC, sampled when redirect_valid is high.
REQ-010 SHALL provide port out_valid  output  1  decode-side instruction valid.
REQ-011 SHALL provide port out_ready  input  1  decode stage accepts the output this cycle.
REQ-012 SHALL provide port out_instr  output  32  fetched instruction.
REQ-013 SHALL provide port out_pc  output  ADDR_W  PC of out_instr.

Function
REQ-014 SHALL drive imem_addr from the PC register, combinationally, with no added latency.
REQ-015 SHALL define the IF/ID register as able to load when out_valid==0 or out_ready==1.
REQ-016 SHALL, when it can load and neither halt nor redirect_valid is high, at the clock edge: capture out_instr<=imem_instr, out_pc<=PC, out_valid<=1, PC<=PC+1.
REQ-017 SHALL compute PC+1 modulo 2^ADDR_W, so PC 31 wraps to 0 with ADDR_W=5.
REQ-018 SHALL, when it cannot load (out_valid==1 and out_ready==0), hold PC, out_instr, out_pc and out_valid unchanged.
REQ-019 SHALL, when halt==1 and redirect_valid==0, hold PC and fetch nothing; a pending output remains valid until accepted, and after acceptance out_valid<=0.
REQ-020 SHALL give redirect_valid priority over halt, stall and normal fetch: at the edge, PC<=redirect_pc and out_valid<=0, discarding any pending output whatever the state of out_ready.
REQ-021 SHALL have redirect latency: redirect sampled at edge N causes the instruction at redirect_pc to present with out_valid=1 after edge N+1, provided it is not halted or stalled.
REQ-022 SHALL sustain one instruction per cycle while out_ready==1 continuously and halt==0.
REQ-023 SHALL never change out_instr or out_pc while out_valid==1 and out_ready==0, unless a redirect occurs.

Reset
REQ-024 SHALL on rst==1 immediately set PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, independent of clk.
REQ-025 SHALL, on the first edge after rst deasserts with halt==0, fetch from RESET_PC.
REQ-026 SHALL, if reset is asserted mid-stall or mid-redirect, discard all in-flight state with no residual output.

Configuration
REQ-027 SHALL, with macro FETCH_STALL_CNT_EN defined, add port stall_cnt  output  16  count of cycles with out_valid==1 and out_ready==0, saturating at 0xFFFF, reset to 0.
REQ-028 SHALL, without FETCH_STALL_CNT_EN, omit the stall_cnt port and counter logic; all other behaviour is identical.

Verification
REQ-029 SHALL verify: reset release, out_ready=1 held, imem preloaded mem[0..4] -> out_pc 0,1,2,3,4 on consecutive cycles, out_instr matching mem contents, out_valid=1 from the first post-reset edge.
REQ-030 SHALL verify: out_ready=0 for 3 cycles while out_pc=2 -> out_pc/out_instr held at 2, imem_addr held at 3; with the macro on, stall_cnt=3; resume -> out_pc 3 next.
REQ-031 SHALL verify: redirect_valid=1, redirect_pc=20 while out_ready=0 -> out_valid=0 next cycle, then out_pc=20 one cycle later.
REQ-032 SHALL verify: fetch run through PC 31 -> next out_pc=0 (wrap).
REQ-033 SHALL verify: halt=1 with a valid pending output and out_ready=1 -> one acceptance, then out_valid=0, PC frozen; halt=1 together with redirect to 7 -> PC=7, out_valid=0.
REQ-034 SHALL verify: rst pulsed asynchronously mid-stream at PC=9 -> out_valid=0 and imem_addr=RESET_PC before the next clock edge.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - decode-side instruction stream between fetch and decode
interface fetch_unit_if #(
    parameter int ADDR_W = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and IF/ID stage; FETCH_STALL_CNT_EN adds a stall_cnt output
module fetch_unit #(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    fetch_unit_if.master      dec
);

    logic [ADDR_W-1:0] pc;
    logic              valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] opc_q;
    logic              can_load;

    // The IF/ID register may be overwritten once its current content is gone or taken.
    assign can_load  = !valid_q || dec.out_ready;
    assign imem_addr = pc;

    assign dec.out_valid = valid_q;
    assign dec.out_instr = instr_q;
    assign dec.out_pc    = opc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
        end else if (redirect_valid) begin
            // Flush wins over everything, including an output the consumer is taking now.
            pc      <= redirect_pc;
            valid_q <= 1'b0;
        end else if (can_load) begin
            if (halt) begin
                valid_q <= 1'b0;
            end else begin
                instr_q <= imem_instr;
                opc_q   <= pc;
                valid_q <= 1'b1;
                pc      <= pc + 1'b1;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (valid_q && !dec.out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              halt;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    logic [31:0] mem [32];
    int checks;
    int failures;

    fetch_unit_if #(.ADDR_W(ADDR_W)) dec ();

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(5'd0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .dec            (dec.master)
    );

    assign imem_instr = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input int p);
        return 32'hC0DE_0000 + 32'(p);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) mem[i] = word_at(i);

        rst            = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec.out_ready  = 1'b1;
        #2;
        check("rst_valid", 32'(dec.out_valid), 32'd0);
        check("rst_addr",  32'(imem_addr),     32'd0);
        check("rst_instr", dec.out_instr,      32'd0);
        check("rst_pc",    32'(dec.out_pc),    32'd0);
        tick;
        tick;
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            tick;
            check("run_valid", 32'(dec.out_valid), 32'd1);
            check("run_pc",    32'(dec.out_pc),    32'(k));
            check("run_instr", dec.out_instr,      word_at(k));
            check("run_addr",  32'(imem_addr),     32'(k + 1));
        end

        redirect_valid = 1'b1;
        redirect_pc    = 5'd2;
        tick;
        check("redir2_valid", 32'(dec.out_valid), 32'd0);
        check("redir2_addr",  32'(imem_addr),     32'd2);
        redirect_valid = 1'b0;
        tick;
        check("redir2_pc", 32'(dec.out_pc), 32'd2);

        dec.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("stall_valid", 32'(dec.out_valid), 32'd1);
            check("stall_pc",    32'(dec.out_pc),    32'd2);
            check("stall_instr", dec.out_instr,      word_at(2));
            check("stall_addr",  32'(imem_addr),     32'd3);
        end
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'd3);
`endif
        dec.out_ready = 1'b1;
        tick;
        check("resume_pc", 32'(dec.out_pc), 32'd3);

        dec.out_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 5'd20;
        tick;
        check("redir20_valid", 32'(dec.out_valid), 32'd0);
        check("redir20_addr",  32'(imem_addr),     32'd20);
        redirect_valid = 1'b0;
        dec.out_ready  = 1'b1;
        tick;
        check("redir20_v2",    32'(dec.out_valid), 32'd1);
        check("redir20_pc",    32'(dec.out_pc),    32'd20);
        check("redir20_instr", dec.out_instr,      word_at(20));

        for (int k = 21; k < 32; k++) begin
            tick;
            check("tail_pc", 32'(dec.out_pc), 32'(k));
        end
        tick;
        check("wrap_pc",    32'(dec.out_pc), 32'd0);
        check("wrap_instr", dec.out_instr,   word_at(0));
        check("wrap_addr",  32'(imem_addr),  32'd1);

        halt          = 1'b1;
        dec.out_ready = 1'b0;
        tick;
        check("halt_hold_valid", 32'(dec.out_valid), 32'd1);
        check("halt_hold_pc",    32'(dec.out_pc),    32'd0);
        check("halt_hold_addr",  32'(imem_addr),     32'd1);
        dec.out_ready = 1'b1;
        tick;
        check("halt_acc_valid", 32'(dec.out_valid), 32'd0);
        check("halt_acc_addr",  32'(imem_addr),     32'd1);
        tick;
        check("halt_idle_valid", 32'(dec.out_valid), 32'd0);
        check("halt_idle_addr",  32'(imem_addr),     32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 5'd7;
        tick;
        check("halt_redir_addr",  32'(imem_addr),     32'd7);
        check("halt_redir_valid", 32'(dec.out_valid), 32'd0);
        redirect_valid = 1'b0;
        halt           = 1'b0;
        tick;
        check("after7_pc",   32'(dec.out_pc),  32'd7);
        check("after7_addr", 32'(imem_addr),   32'd8);
        tick;
        check("pre_rst_addr", 32'(imem_addr), 32'd9);

        rst = 1'b1;
        #1;
        check("arst_valid", 32'(dec.out_valid), 32'd0);
        check("arst_addr",  32'(imem_addr),     32'd0);
        check("arst_pc",    32'(dec.out_pc),    32'd0);
        check("arst_instr", dec.out_instr,      32'd0);
`ifdef FETCH_STALL_CNT_EN
        check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        #1;
        rst = 1'b0;
        tick;
        check("post_rst_valid", 32'(dec.out_valid), 32'd1);
        check("post_rst_pc",    32'(dec.out_pc),    32'd0);
        check("post_rst_instr", dec.out_instr,      word_at(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
